// File: rtl/dlx_pkg.sv
// ---------------------------------------------------------------------------
// dlx_pkg
// Shared definitions for the DLX multicycle sequencer.
//   stage_e    : encoded phase of the sequencer, also exported as a debug code
//   NUM_STAGES : number of active phases per instruction (IF..WB)
// ---------------------------------------------------------------------------
package dlx_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      S_IF  = 3'd1,
      S_ID  = 3'd2,
      S_EX  = 3'd3,
      S_MEM = 3'd4,
      S_WB  = 3'd5
   } stage_e;

   localparam int NUM_STAGES = 5;

endpackage

// File: rtl/dlx_wrap_counter.sv
// ---------------------------------------------------------------------------
// dlx_wrap_counter
// Free-running event counter that wraps modulo 2^W.
//   clk     : system clock
//   reset_n : synchronous active-low clear
//   inc     : count one event on this rising edge
//   count   : current event count
// ---------------------------------------------------------------------------
module dlx_wrap_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Clear on reset, otherwise add one per event. Overflow simply wraps,
   // there is deliberately no saturation or overflow flag.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= '0;
      end else if (inc) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/dlx_ctrl.sv
// ---------------------------------------------------------------------------
// dlx_ctrl
// Multicycle sequencer for the DLX datapath. Walks each instruction through
// IF, ID, EX, MEM and WB, one phase per clock, and starts the next one.
//   clk            : system clock
//   reset_n        : synchronous active-low reset
//   IF/ID/EX/MEM/WB: one-hot phase enables into the datapath
//   stage          : encoded current phase (dlx_pkg::stage_e)
//   instr_count    : number of completed WB phases since reset
// ---------------------------------------------------------------------------
module dlx_ctrl
   import dlx_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   output logic             IF,
   output logic             ID,
   output logic             EX,
   output logic             MEM,
   output logic             WB,
   output logic [2:0]       stage,
   output logic [CNT_W-1:0] instr_count
);

   stage_e state;
   stage_e state_nxt;
   logic   retire;

   // State register. Reset has priority over every transition, so an
   // instruction caught mid-flight is dropped and never retired.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and strobe decode. Strobes depend only on the state
   // register, so reset_n never reaches an output combinationally.
   // Unused encodings fall into the default arm: strobes stay low and the
   // machine drops back to IDLE on the next edge.
   always_comb begin
      state_nxt = IDLE;
      IF        = 1'b0;
      ID        = 1'b0;
      EX        = 1'b0;
      MEM       = 1'b0;
      WB        = 1'b0;
      retire    = 1'b0;
      case (state)
         IDLE:  state_nxt = S_IF;
         S_IF:  begin
            IF        = 1'b1;
            state_nxt = S_ID;
         end
         S_ID:  begin
            ID        = 1'b1;
            state_nxt = S_EX;
         end
         S_EX:  begin
            EX        = 1'b1;
            state_nxt = S_MEM;
         end
         S_MEM: begin
            MEM       = 1'b1;
            state_nxt = S_WB;
         end
         S_WB:  begin
            WB        = 1'b1;
            retire    = 1'b1;
            state_nxt = S_IF;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign stage = state;

   // Retired-instruction counter: bumps on the edge that leaves WB.
   dlx_wrap_counter #(
      .W(CNT_W)
   ) u_count (
      .clk    (clk),
      .reset_n(reset_n),
      .inc    (retire),
      .count  (instr_count)
   );

endmodule

// File: tb/tb_dlx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dlx_ctrl
// Self-checking bench for dlx_ctrl. Two instances share clock and reset:
// one with the default 32-bit counter and one with a 2-bit counter so the
// wrap-around is reachable quickly.
// ---------------------------------------------------------------------------
module tb_dlx_ctrl;
   import dlx_pkg::*;

   logic        clk;
   logic        reset_n;

   logic        IF, ID, EX, MEM, WB;
   logic [2:0]  stage;
   logic [31:0] instr_count;

   logic        IF2, ID2, EX2, MEM2, WB2;
   logic [2:0]  stage2;
   logic [1:0]  instr_count2;

   int checkCount;
   int errorCount;
   int edgesSinceReset;

   dlx_ctrl #(.CNT_W(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .IF         (IF),
      .ID         (ID),
      .EX         (EX),
      .MEM        (MEM),
      .WB         (WB),
      .stage      (stage),
      .instr_count(instr_count)
   );

   dlx_ctrl #(.CNT_W(2)) dut2 (
      .clk        (clk),
      .reset_n    (reset_n),
      .IF         (IF2),
      .ID         (ID2),
      .EX         (EX2),
      .MEM        (MEM2),
      .WB         (WB2),
      .stage      (stage2),
      .instr_count(instr_count2)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: only counts rising edges since the last reset edge.
   // Everything else is derived arithmetically from that count.
   always @(posedge clk) begin
      if (!reset_n) begin
         edgesSinceReset = 0;
      end else if (edgesSinceReset >= 0) begin
         edgesSinceReset = edgesSinceReset + 1;
      end
   end

   // Count one comparison and report it when it disagrees.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                  tag, $time, observed, expected);
      end
   endtask

   // Compare both instances against the edge-count model.
   task automatic compareModel();
      int         k;
      int         expStage;
      int         expRetired;
      logic [4:0] expStrobes;
      k          = edgesSinceReset;
      expStage   = (k == 0) ? 0 : ((k - 1) % NUM_STAGES) + 1;
      expRetired = (k == 0) ? 0 : (k - 1) / NUM_STAGES;
      expStrobes = (expStage == 0) ? 5'b00000 : 5'b10000 >> (expStage - 1);
      checkOutput("stage",   32'(stage),  32'(expStage));
      checkOutput("strobes", 32'({IF, ID, EX, MEM, WB}), 32'(expStrobes));
      checkOutput("count",   instr_count, 32'(expRetired));
      checkOutput("stage2",  32'(stage2), 32'(expStage));
      checkOutput("strobes2", 32'({IF2, ID2, EX2, MEM2, WB2}), 32'(expStrobes));
      checkOutput("count2",  32'(instr_count2), 32'(expRetired % 4));
      if (expStage != 0) begin
         checkOutput("onehot", 32'($onehot({IF, ID, EX, MEM, WB})), 32'd1);
      end
   endtask

   // Drive reset_n for the next rising edge, then sample on the falling edge.
   task automatic applyStimulus(input logic rst_n);
      reset_n = rst_n;
      @(negedge clk);
      compareModel();
   endtask

   logic [4:0] firstSeq [6];
   logic [1:0] wrapSeq  [4];
   bit         foundEx;

   initial begin
      checkCount      = 0;
      errorCount      = 0;
      edgesSinceReset = -1;
      firstSeq = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
      wrapSeq  = '{2'd1, 2'd2, 2'd3, 2'd0};

      // Reset held across the 5 ns edge.
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput("rst_strobes", 32'({IF, ID, EX, MEM, WB}), 32'd0);
      checkOutput("rst_stage",   32'(stage), 32'd0);
      checkOutput("rst_count",   instr_count, 32'd0);

      // Release at 10 ns; first full instruction against fixed expectations.
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("first_seq", 32'({IF, ID, EX, MEM, WB}), 32'(firstSeq[i]));
      end
      checkOutput("first_count", instr_count, 32'd1);

      // Free-running for 100 cycles.
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1);
      end

      // Reset asserted while EX is high.
      foundEx = 1'b0;
      for (int i = 0; i < 10 && !foundEx; i++) begin
         if (EX) foundEx = 1'b1;
         else    applyStimulus(1'b1);
      end
      checkOutput("find_ex", 32'(foundEx), 32'd1);
      applyStimulus(1'b0);
      checkOutput("mid_rst_strobes", 32'({IF, ID, EX, MEM, WB}), 32'd0);
      checkOutput("mid_rst_count",   instr_count, 32'd0);
      applyStimulus(1'b1);
      checkOutput("mid_rst_if", 32'(IF), 32'd1);

      // 2-bit counter wrap over four instructions from a fresh reset.
      applyStimulus(1'b0);
      reset_n = 1'b1;
      for (int i = 1; i <= 21; i++) begin
         @(negedge clk);
         if (i % 5 == 1 && i > 1) begin
            checkOutput("wrap", 32'(instr_count2), 32'(wrapSeq[(i / 5) - 1]));
         end
      end

      // Randomised reset pulses, checked every cycle against the model.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0);
      end

      // Illegal encoding: hold state at 7 for one cycle, release before the edge.
      applyStimulus(1'b1);
      force dut.state = stage_e'(3'd7);
      #1;
      checkOutput("illegal_strobes", 32'({IF, ID, EX, MEM, WB}), 32'd0);
      #2;
      release dut.state;
      @(negedge clk);
      checkOutput("illegal_recover", 32'(stage), 32'd0);
      @(negedge clk);
      checkOutput("illegal_if", 32'({IF, ID, EX, MEM, WB}), 32'b10000);

      // Back to model checking after a clean reset.
      applyStimulus(1'b0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/dlx_ctrl.md
Name: dlx_ctrl

Overview:
- Multicycle sequencer for the DLX datapath.
- Steps one instruction through the five phases IF, ID, EX, MEM and WB, one phase per clock, then repeats.
- Drives one-hot phase-enable strobes into the datapath (fetch, register read, ALU, memory, register write-back).
- Also exports an encoded phase code and a retired-instruction counter for debug and performance monitoring.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instr_count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- IF  output  1  instruction-fetch phase enable.
- ID  output  1  instruction-decode / register-read phase enable.
- EX  output  1  execute phase enable.
- MEM  output  1  memory-access phase enable.
- WB  output  1  write-back phase enable.
- stage  output  3  encoded current phase (dlx_pkg::stage_e).
- instr_count  output  CNT_W  number of completed WB phases since reset.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-low (reset_n). There is no asynchronous path.
- State register holds one of six states, with these stage codes: IDLE=0, S_IF=1, S_ID=2, S_EX=3, S_MEM=4, S_WB=5.
- Reset: on any rising edge with reset_n=0:
  - state <= IDLE and instr_count <= 0.
  - IF, ID, EX, MEM and WB are all 0; stage=0.
  - Reset wins over every transition, including reset asserted mid-instruction. The partially executed instruction is abandoned and not counted.
- Transitions on each rising edge with reset_n=1: IDLE->S_IF, S_IF->S_ID, S_ID->S_EX, S_EX->S_MEM, S_MEM->S_WB, S_WB->S_IF. No stalls, no skipped phases.
- Outputs are Moore, decoded only from the state register:
  - IF=(state==S_IF), ID=(state==S_ID), EX=(state==S_EX), MEM=(state==S_MEM), WB=(state==S_WB).
  - Exactly one strobe is high in any non-IDLE state; all are low in IDLE.
  - No combinational path from reset_n to any output.
- Latency:
  - The first rising edge after reset_n returns high moves IDLE->S_IF.
  - IF is then high for one cycle; each strobe is high exactly 1 cycle.
  - The period is 5 cycles per instruction.
- instr_count increments by 1 on each edge leaving S_WB (S_WB->S_IF). It wraps modulo 2^CNT_W with no saturation and no flag.
- Illegal or unused state encodings (6, 7) recover to IDLE on the next edge; all strobes read 0 while in them.
- Before the first clock edge, state is undefined. The bench must apply reset for at least one rising edge.

Decomposition:
- Package dlx_pkg: typedef enum logic [2:0] stage_e {IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB} with the codes above; localparam NUM_STAGES=5.
- Module body: one always_ff for state plus counter, and one always_comb for next-state and strobe decode.
- No sub-module is required. The counter may optionally be factored as dlx_wrap_counter (parameter W, inputs clk/reset_n/inc, output count).

Test Plan:
- Reset hold: clk period 10 ns, reset_n=0 for the edge at 5 ns -> IF=ID=EX=MEM=WB=0, stage=0, instr_count=0.
- Release and first sequence: reset_n=1 at 10 ns.
  - After the edge at 15 ns: IF=1. Edges at 25/35/45/55 ns give ID, EX, MEM, WB high respectively, each for exactly one cycle.
  - After the edge at 65 ns: IF=1 again and instr_count=1.
- One-hot check: over 100 cycles of free-running, $onehot({IF,ID,EX,MEM,WB}) every cycle, and stage matches the strobe (IF↔1 … WB↔5).
- Mid-instruction reset: drop reset_n while EX=1 for one edge -> next cycle all strobes 0, stage=0, instr_count=0. After release, IF=1 one edge later.
- Counter wrap: CNT_W=2, run 4 full instructions -> instr_count sequence 1, 2, 3, 0.
- Illegal state recovery: force state=7 for one cycle (bench force/release) -> strobes 0 while forced. Next edge: stage=0. Following edge: IF=1.
